// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment width and the
// active-low hex glyph table, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = GLYPH[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with per-digit blank/blink, anti-ghost
// guard at each slot start, and registered active-low outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    output logic [DIGITS-1:0]     an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp
);

    localparam int CW = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int IW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame;
    logic                  phase;

    logic [4*DIGITS-1:0]   hex_s;
    logic [DIGITS-1:0]     dp_s;
    logic [DIGITS-1:0]     blank_s;
    logic [DIGITS-1:0]     blink_s;

    logic [3:0]            cur_hex;
    seg_t                  glyph;
    logic                  slot_end;
    logic                  frame_end;
    logic                  dark;

    assign cur_hex   = hex_s[4*idx +: 4];
    assign slot_end  = (cnt == CW'(CLK_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
    assign dark      = (cnt < CW'(GUARD)) || blank_s[idx] || (blink_s[idx] && phase);

    seg7_hex_glyph u_glyph (
        .hex (cur_hex),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            frame   <= '0;
            phase   <= 1'b0;
            hex_s   <= '0;
            dp_s    <= '0;
            blank_s <= '0;
            blink_s <= '0;
            an      <= '1;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
        end else begin
            if (load) begin
                hex_s   <= hex_data;
                dp_s    <= dp_in;
                blank_s <= blank;
                blink_s <= blink;
            end

            if (slot_end) begin
                cnt <= '0;
                idx <= frame_end ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Blink phase flips once every BLINK_FRAMES complete scans.
            if (frame_end) begin
                if (frame == FW'(BLINK_FRAMES - 1)) begin
                    frame <= '0;
                    phase <= ~phase;
                end else begin
                    frame <= frame + 1'b1;
                end
            end

            if (dark) begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= ~(DIGITS'(1) << idx);
                seg <= glyph;
                dp  <= ~dp_s[idx];
            end
        end
    end

endmodule
